// File: rtl/nibble_tx_pkg.sv
// Shared types and constants for the nibble serial transmitter.
// Frame: start, data LSB first, even parity, stop.
package nibble_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    function automatic int frame_clks(input int data_w, input int clks_per_bit);
        return (data_w + 3) * clks_per_bit;
    endfunction

endpackage

// File: rtl/nibble_serial_tx_bit_timer.sv
// Bit-time counter: counts 0..CLKS_PER_BIT-1 and flags the last clock of a bit.
// Held at zero while restart is high so a new frame starts on a clean bit.
module nibble_serial_tx_bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_restart,
    output logic o_bit_end
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] r_cnt;
    logic          w_at_last;

    assign w_at_last = (r_cnt == LAST);
    assign o_bit_end = ~i_restart & w_at_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_restart || w_at_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/nibble_serial_tx.sv
// Framed parallel-to-serial transmitter with a one-word holding buffer.
// tx is registered from the next-state level so it changes on state edges.
module nibble_serial_tx
    import nibble_tx_pkg::*;
#(
    parameter int DATA_W       = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    state_t            r_state;
    logic [DATA_W-1:0] r_buf;
    logic              r_full;
    logic [DATA_W-1:0] r_shift;
    logic              r_par;
    logic [BW-1:0]     r_bitcnt;
    logic              r_tx;
    logic              r_busy;
    logic              r_done;

    state_t            w_state_nx;
    logic [DATA_W-1:0] w_shift_nx;
    logic              w_par_nx;
    logic [BW-1:0]     w_bitcnt_nx;
    logic              w_tx_nx;
    logic              w_done_nx;
    logic              w_load;
    logic              w_accept;
    logic              w_bit_end;

    assign din_ready = ~r_full;
    assign tx        = r_tx;
    assign busy      = r_busy;
    assign done      = r_done;
    assign w_accept  = din_valid & ~r_full;

    nibble_serial_tx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_restart (r_state == IDLE),
        .o_bit_end (w_bit_end)
    );

    always_comb begin
        w_state_nx  = r_state;
        w_shift_nx  = r_shift;
        w_par_nx    = r_par;
        w_bitcnt_nx = r_bitcnt;
        w_done_nx   = 1'b0;
        w_load      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (r_full) begin
                    w_load     = 1'b1;
                    w_state_nx = START;
                end
            end
            START: begin
                if (w_bit_end) w_state_nx = DATA;
            end
            DATA: begin
                if (w_bit_end) begin
                    w_shift_nx = r_shift >> 1;
                    if (r_bitcnt == LAST_BIT) begin
                        w_bitcnt_nx = '0;
                        w_state_nx  = PARITY;
                    end else begin
                        w_bitcnt_nx = r_bitcnt + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (w_bit_end) w_state_nx = STOP;
            end
            STOP: begin
                if (w_bit_end) begin
                    w_done_nx = 1'b1;
                    // A waiting word starts immediately: no idle bit between frames.
                    if (r_full) begin
                        w_load     = 1'b1;
                        w_state_nx = START;
                    end else begin
                        w_state_nx = IDLE;
                    end
                end
            end
            default: w_state_nx = IDLE;
        endcase
        if (w_load) begin
            w_shift_nx  = r_buf;
            w_par_nx    = ^r_buf;
            w_bitcnt_nx = '0;
        end
    end

    always_comb begin
        w_tx_nx = IDLE_LEVEL;
        unique case (w_state_nx)
            IDLE:    w_tx_nx = IDLE_LEVEL;
            START:   w_tx_nx = START_LEVEL;
            DATA:    w_tx_nx = w_shift_nx[0];
            PARITY:  w_tx_nx = w_par_nx;
            STOP:    w_tx_nx = STOP_LEVEL;
            default: w_tx_nx = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_shift  <= '0;
            r_par    <= 1'b0;
            r_bitcnt <= '0;
            r_tx     <= IDLE_LEVEL;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_shift  <= w_shift_nx;
            r_par    <= w_par_nx;
            r_bitcnt <= w_bitcnt_nx;
            r_tx     <= w_tx_nx;
            r_busy   <= (w_state_nx != IDLE);
            r_done   <= w_done_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full <= 1'b0;
            r_buf  <= '0;
        end else if (w_accept) begin
            r_full <= 1'b1;
            r_buf  <= din;
        end else if (w_load) begin
            r_full <= 1'b0;
        end
    end

endmodule

// File: tb/tb_nibble_serial_tx.sv
// Bench for nibble_serial_tx: frame-position reference model checked every
// cycle, plus table-driven frames and hand-written corner sequences.
module tb_nibble_serial_tx;
    import nibble_tx_pkg::*;

    localparam int W   = 4;
    localparam int CPB = 2;
    localparam int F   = frame_clks(W, CPB);

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] din = '0;
    logic         din_valid = 1'b0;
    logic         din_ready;
    logic         tx;
    logic         busy;
    logic         done;

    always #5 clk = ~clk;

    nibble_serial_tx #(
        .DATA_W       (W),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .tx        (tx),
        .busy      (busy),
        .done      (done)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: position within the current frame, plus a 1-deep buffer.
    int           m_t = -1;
    logic         m_full = 1'b0;
    logic         m_acc;
    logic         m_done = 1'b0;
    logic [W-1:0] m_buf = '0;
    logic [W-1:0] m_cur = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t    = -1;
            m_full = 1'b0;
            m_done = 1'b0;
        end else begin
            m_acc  = din_valid && !m_full;
            m_done = 1'b0;
            if (m_t >= 0) begin
                m_t++;
                if (m_t == F) begin
                    m_t    = -1;
                    m_done = 1'b1;
                end
            end
            if (m_t < 0 && m_full) begin
                m_cur  = m_buf;
                m_full = 1'b0;
                m_t    = 0;
            end
            if (m_acc) begin
                m_full = 1'b1;
                m_buf  = din;
            end
        end
    end

    function automatic logic m_tx();
        int idx;
        if (m_t < 0) return 1'b1;
        idx = m_t / CPB;
        if (idx == 0) return 1'b0;
        if (idx <= W) return m_cur[idx-1];
        if (idx == W + 1) return ^m_cur;
        return 1'b1;
    endfunction

    int   n_done = 0;
    bit   b2b_on = 0;
    logic b2b_tx[$];

    always @(negedge clk) begin
        chk("model_tx", tx, m_tx());
        chk("model_ready", din_ready, !m_full);
        chk("model_busy", busy, m_t >= 0);
        chk("model_done", done, m_done);
        if (done === 1'b1) begin
            n_done++;
            if (b2b_on) b2b_tx.push_back(tx);
        end
    end

    // Called just after a negedge; returns just after the negedge following the accept.
    task automatic offer(input logic [W-1:0] w, input bit keep);
        int n;
        n = 0;
        din = w;
        din_valid = 1'b1;
        while (!din_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL offer_timeout: got no din_ready, expected within 200 cycles");
        end
        @(posedge clk);
        @(negedge clk);
        if (!keep) begin
            din_valid = 1'b0;
            din = W'($urandom);
        end
    endtask

    task automatic wait_done(input int target, input int limit);
        int n;
        n = 0;
        while (n_done < target && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("wait_done_count", n_done, target);
    endtask

    typedef struct {
        logic [W-1:0] din;
        logic [6:0]   bits;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int d0;
        vecs[0] = '{4'b0101, 7'b1001010};
        vecs[1] = '{4'b0111, 7'b1101110};
        vecs[2] = '{4'b0000, 7'b1000000};
        vecs[3] = '{4'b1010, 7'b1010100};

        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_ready", din_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            d0 = n_done;
            offer(vecs[i].din, 0);
            for (int k = 0; k < F; k++) begin
                @(negedge clk);
                chk($sformatf("vec%0d_bit%0d", i, k), tx, vecs[i].bits[k/CPB]);
                chk($sformatf("vec%0d_busy%0d", i, k), busy, 1);
            end
            @(negedge clk);
            chk($sformatf("vec%0d_done", i), done, 1);
            chk($sformatf("vec%0d_busy_end", i), busy, 0);
            chk($sformatf("vec%0d_tx_idle", i), tx, 1);
            repeat (3) @(negedge clk);
            chk($sformatf("vec%0d_ndone", i), n_done - d0, 1);
        end

        d0 = n_done;
        b2b_on = 1;
        offer(4'b1010, 1);
        offer(4'b0011, 1);
        chk("b2b_busy_at_accept2", busy, 1);
        chk("b2b_ready_full", din_ready, 0);
        offer(4'b0110, 0);
        chk("b2b_busy_at_accept3", busy, 1);
        wait_done(d0 + 3, 4 * F + 20);
        repeat (2) @(negedge clk);
        b2b_on = 0;
        chk("b2b_pulses", b2b_tx.size(), 3);
        if (b2b_tx.size() == 3) begin
            chk("b2b_gap1", b2b_tx[0], 0);
            chk("b2b_gap2", b2b_tx[1], 0);
            chk("b2b_last_idle", b2b_tx[2], 1);
        end

        for (int c = 0; c < 400; c++) begin
            din = W'($urandom);
            din_valid = ($urandom_range(0, 3) == 0);
            @(negedge clk);
        end
        din_valid = 1'b0;
        repeat (3 * F) @(negedge clk);

        d0 = n_done;
        offer(4'b1011, 0);
        offer(4'b0110, 0);
        repeat (2 * CPB + 1) @(negedge clk);
        chk("mid_busy_before_rst", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_tx", tx, 1);
        chk("mid_rst_ready", din_ready, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * F) @(negedge clk);
        chk("mid_rst_no_done", n_done - d0, 0);
        offer(4'b0111, 0);
        wait_done(d0 + 1, F + 10);
        repeat (3) @(negedge clk);
        chk("post_rst_ndone", n_done - d0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
